// File: rtl/dec_rat_pkg.sv
// Shared widths and types for the decode-stage register alias table.
package dec_rat_pkg;

    localparam int unsigned ARCH_REG_WIDTH     = 5;
    // Must track the shared PRF code width used by the freelist and ROB.
    localparam int unsigned DEF_PRF_CODE_WIDTH = 7;
    localparam int unsigned RENAME_WIDTH       = 4;
    localparam int unsigned COMMIT_WIDTH       = 4;

    typedef logic [ARCH_REG_WIDTH-1:0] arch_idx_t;

endpackage

// File: rtl/dec_rat_bypass_module.sv
// Priority match of one arch index against the destinations of older slots in the
// same rename group; the youngest matching older slot supplies the PRF code.
module dec_rat_bypass_module
    import dec_rat_pkg::*;
#(
    parameter int unsigned NumOlder = 1,
    parameter int unsigned PrfW     = DEF_PRF_CODE_WIDTH
) (
    input  arch_idx_t                      idx_i,
    input  arch_idx_t [NumOlder-1:0]       older_rd_i,
    input  logic      [NumOlder-1:0]       older_wen_i,
    input  logic      [NumOlder-1:0][PrfW-1:0] older_prd_i,
    input  logic      [PrfW-1:0]           dflt_prd_i,
    output logic      [PrfW-1:0]           prd_o
);

    always_comb begin
        prd_o = dflt_prd_i;
        for (int j = 0; j < NumOlder; j++) begin
            if (older_wen_i[j] && (older_rd_i[j] == idx_i)) begin
                prd_o = older_prd_i[j];
            end
        end
    end

endmodule

// File: rtl/gnrl_dfflr.sv
// Generic load-enabled flop with asynchronous active-low reset to a fixed value.
module gnrl_dfflr #(
    parameter int unsigned   DW            = 1,
    parameter logic [DW-1:0] INITIAL_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          lden_i,
    input  logic [DW-1:0] dnxt_i,
    output logic [DW-1:0] qout_o
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            qout_o <= INITIAL_VALUE;
        end else if (lden_i) begin
            qout_o <= dnxt_i;
        end
    end

endmodule

// File: rtl/dec_rat_module.sv
// 4-wide register alias table: renames a decode group against the speculative RAT,
// tracks the committed RAT, and restores the speculative copy on flush.
module dec_rat_module
    import dec_rat_pkg::*;
#(
    parameter int unsigned ARCH_REGS      = 32,
    parameter int unsigned PRF_CODE_WIDTH = DEF_PRF_CODE_WIDTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_rat_vld_0,
    input  logic                      i_rat_vld_1,
    input  logic                      i_rat_vld_2,
    input  logic                      i_rat_vld_3,
    input  logic [4:0]                i_rat_rs1_0,
    input  logic [4:0]                i_rat_rs1_1,
    input  logic [4:0]                i_rat_rs1_2,
    input  logic [4:0]                i_rat_rs1_3,
    input  logic [4:0]                i_rat_rs2_0,
    input  logic [4:0]                i_rat_rs2_1,
    input  logic [4:0]                i_rat_rs2_2,
    input  logic [4:0]                i_rat_rs2_3,
    input  logic [4:0]                i_rat_rd_0,
    input  logic [4:0]                i_rat_rd_1,
    input  logic [4:0]                i_rat_rd_2,
    input  logic [4:0]                i_rat_rd_3,
    input  logic                      i_rat_rd_wen_0,
    input  logic                      i_rat_rd_wen_1,
    input  logic                      i_rat_rd_wen_2,
    input  logic                      i_rat_rd_wen_3,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_new_prd_0,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_new_prd_1,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_new_prd_2,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_new_prd_3,
    input  logic                      i_rat_fl_stall,
    input  logic                      i_rat_dsp_stall,
    input  logic                      i_rat_flush,
    input  logic                      i_rat_cmt_vld_0,
    input  logic                      i_rat_cmt_vld_1,
    input  logic                      i_rat_cmt_vld_2,
    input  logic                      i_rat_cmt_vld_3,
    input  logic [4:0]                i_rat_cmt_rd_0,
    input  logic [4:0]                i_rat_cmt_rd_1,
    input  logic [4:0]                i_rat_cmt_rd_2,
    input  logic [4:0]                i_rat_cmt_rd_3,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_cmt_prd_0,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_cmt_prd_1,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_cmt_prd_2,
    input  logic [PRF_CODE_WIDTH-1:0] i_rat_cmt_prd_3,
    output logic                      o_rat_vld_0,
    output logic                      o_rat_vld_1,
    output logic                      o_rat_vld_2,
    output logic                      o_rat_vld_3,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs1_0,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs1_1,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs1_2,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs1_3,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs2_0,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs2_1,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs2_2,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prs2_3,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prd_0,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prd_1,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prd_2,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_prd_3,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_old_prd_0,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_old_prd_1,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_old_prd_2,
    output logic [PRF_CODE_WIDTH-1:0] o_rat_old_prd_3,
    output logic                      o_rat_stall
);

    typedef logic [RENAME_WIDTH-1:0][PRF_CODE_WIDTH-1:0] prf_vec_t;

    arch_idx_t [RENAME_WIDTH-1:0] rs1, rs2, rd;
    arch_idx_t [COMMIT_WIDTH-1:0] cmt_rd;
    logic      [RENAME_WIDTH-1:0] vld, rd_wen, eff_wen;
    logic      [COMMIT_WIDTH-1:0] cmt_vld;
    prf_vec_t                     new_prd;
    logic [COMMIT_WIDTH-1:0][PRF_CODE_WIDTH-1:0] cmt_prd;

    assign vld     = {i_rat_vld_3, i_rat_vld_2, i_rat_vld_1, i_rat_vld_0};
    assign rs1     = {i_rat_rs1_3, i_rat_rs1_2, i_rat_rs1_1, i_rat_rs1_0};
    assign rs2     = {i_rat_rs2_3, i_rat_rs2_2, i_rat_rs2_1, i_rat_rs2_0};
    assign rd      = {i_rat_rd_3, i_rat_rd_2, i_rat_rd_1, i_rat_rd_0};
    assign rd_wen  = {i_rat_rd_wen_3, i_rat_rd_wen_2, i_rat_rd_wen_1, i_rat_rd_wen_0};
    assign new_prd = {i_rat_new_prd_3, i_rat_new_prd_2, i_rat_new_prd_1, i_rat_new_prd_0};
    assign cmt_vld = {i_rat_cmt_vld_3, i_rat_cmt_vld_2, i_rat_cmt_vld_1, i_rat_cmt_vld_0};
    assign cmt_rd  = {i_rat_cmt_rd_3, i_rat_cmt_rd_2, i_rat_cmt_rd_1, i_rat_cmt_rd_0};
    assign cmt_prd = {i_rat_cmt_prd_3, i_rat_cmt_prd_2, i_rat_cmt_prd_1, i_rat_cmt_prd_0};

    logic stall, accept;
    assign stall       = i_rat_fl_stall | i_rat_dsp_stall;
    assign o_rat_stall = stall;
    assign accept      = (|vld) & ~stall & ~i_rat_flush;

    always_comb begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            eff_wen[k] = vld[k] & rd_wen[k] & (rd[k] != '0);
        end
    end

    logic [PRF_CODE_WIDTH-1:0] srat_q [ARCH_REGS];
    logic [PRF_CODE_WIDTH-1:0] srat_d [ARCH_REGS];
    logic [PRF_CODE_WIDTH-1:0] arat_q [ARCH_REGS];
    logic [PRF_CODE_WIDTH-1:0] arat_d [ARCH_REGS];
    logic [ARCH_REGS-1:0]      srat_en, arat_en;

    // Entry 0 of either table is never written, so x0 always reads back PRF 0.
    always_comb begin
        arat_d  = arat_q;
        arat_en = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            if (cmt_vld[k] && (cmt_rd[k] != '0)) begin
                arat_d[cmt_rd[k]]  = cmt_prd[k];
                arat_en[cmt_rd[k]] = 1'b1;
            end
        end
    end

    always_comb begin
        srat_d  = srat_q;
        srat_en = '0;
        if (i_rat_flush) begin
            srat_d  = arat_d;
            srat_en = '1;
        end else if (accept) begin
            for (int k = 0; k < RENAME_WIDTH; k++) begin
                if (eff_wen[k]) begin
                    srat_d[rd[k]]  = new_prd[k];
                    srat_en[rd[k]] = 1'b1;
                end
            end
        end
    end

    for (genvar r = 0; r < ARCH_REGS; r++) begin : g_tbl
        gnrl_dfflr #(.DW(PRF_CODE_WIDTH), .INITIAL_VALUE('0)) u_srat (
            .clk    (clk),
            .rst_n  (rst_n),
            .lden_i (srat_en[r]),
            .dnxt_i (srat_d[r]),
            .qout_o (srat_q[r])
        );
        gnrl_dfflr #(.DW(PRF_CODE_WIDTH), .INITIAL_VALUE('0)) u_arat (
            .clk    (clk),
            .rst_n  (rst_n),
            .lden_i (arat_en[r]),
            .dnxt_i (arat_d[r]),
            .qout_o (arat_q[r])
        );
    end

    prf_vec_t prs1_d, prs2_d, rd_map, prd_d, old_prd_d;

    assign prs1_d[0] = srat_q[rs1[0]];
    assign prs2_d[0] = srat_q[rs2[0]];
    assign rd_map[0] = srat_q[rd[0]];

    for (genvar k = 1; k < RENAME_WIDTH; k++) begin : g_byp
        dec_rat_bypass_module #(.NumOlder(k), .PrfW(PRF_CODE_WIDTH)) u_byp_rs1 (
            .idx_i       (rs1[k]),
            .older_rd_i  (rd[k-1:0]),
            .older_wen_i (eff_wen[k-1:0]),
            .older_prd_i (new_prd[k-1:0]),
            .dflt_prd_i  (srat_q[rs1[k]]),
            .prd_o       (prs1_d[k])
        );
        dec_rat_bypass_module #(.NumOlder(k), .PrfW(PRF_CODE_WIDTH)) u_byp_rs2 (
            .idx_i       (rs2[k]),
            .older_rd_i  (rd[k-1:0]),
            .older_wen_i (eff_wen[k-1:0]),
            .older_prd_i (new_prd[k-1:0]),
            .dflt_prd_i  (srat_q[rs2[k]]),
            .prd_o       (prs2_d[k])
        );
        dec_rat_bypass_module #(.NumOlder(k), .PrfW(PRF_CODE_WIDTH)) u_byp_rd (
            .idx_i       (rd[k]),
            .older_rd_i  (rd[k-1:0]),
            .older_wen_i (eff_wen[k-1:0]),
            .older_prd_i (new_prd[k-1:0]),
            .dflt_prd_i  (srat_q[rd[k]]),
            .prd_o       (rd_map[k])
        );
    end

    always_comb begin
        for (int k = 0; k < RENAME_WIDTH; k++) begin
            prd_d[k]     = eff_wen[k] ? new_prd[k] : '0;
            old_prd_d[k] = eff_wen[k] ? rd_map[k] : '0;
        end
    end

    logic [RENAME_WIDTH-1:0] vld_q;
    prf_vec_t                prs1_q, prs2_q, prd_q, old_prd_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q     <= '0;
            prs1_q    <= '0;
            prs2_q    <= '0;
            prd_q     <= '0;
            old_prd_q <= '0;
        end else if (i_rat_flush) begin
            vld_q <= '0;
        end else if (!stall) begin
            vld_q <= vld;
            if (|vld) begin
                prs1_q    <= prs1_d;
                prs2_q    <= prs2_d;
                prd_q     <= prd_d;
                old_prd_q <= old_prd_d;
            end
        end
    end

    assign {o_rat_vld_3, o_rat_vld_2, o_rat_vld_1, o_rat_vld_0} = vld_q;
    assign {o_rat_prs1_3, o_rat_prs1_2, o_rat_prs1_1, o_rat_prs1_0} = prs1_q;
    assign {o_rat_prs2_3, o_rat_prs2_2, o_rat_prs2_1, o_rat_prs2_0} = prs2_q;
    assign {o_rat_prd_3, o_rat_prd_2, o_rat_prd_1, o_rat_prd_0} = prd_q;
    assign {o_rat_old_prd_3, o_rat_old_prd_2, o_rat_old_prd_1, o_rat_old_prd_0} = old_prd_q;

endmodule

// File: tb/tb_dec_rat_module.sv
// Randomized bench for dec_rat_module against an array-based rename model, plus
// directed groups with hand-computed expectations.
module tb_dec_rat_module;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]      vld, rd_wen, cmt_vld;
    logic [3:0][4:0] rs1, rs2, rd, cmt_rd;
    logic [3:0][6:0] new_prd, cmt_prd;
    logic            fl_stall, dsp_stall, flush;

    logic [3:0]      o_vld;
    logic [3:0][6:0] o_prs1, o_prs2, o_prd, o_old;
    logic            o_stall;

    dec_rat_module dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .i_rat_vld_0     (vld[0]),
        .i_rat_vld_1     (vld[1]),
        .i_rat_vld_2     (vld[2]),
        .i_rat_vld_3     (vld[3]),
        .i_rat_rs1_0     (rs1[0]),
        .i_rat_rs1_1     (rs1[1]),
        .i_rat_rs1_2     (rs1[2]),
        .i_rat_rs1_3     (rs1[3]),
        .i_rat_rs2_0     (rs2[0]),
        .i_rat_rs2_1     (rs2[1]),
        .i_rat_rs2_2     (rs2[2]),
        .i_rat_rs2_3     (rs2[3]),
        .i_rat_rd_0      (rd[0]),
        .i_rat_rd_1      (rd[1]),
        .i_rat_rd_2      (rd[2]),
        .i_rat_rd_3      (rd[3]),
        .i_rat_rd_wen_0  (rd_wen[0]),
        .i_rat_rd_wen_1  (rd_wen[1]),
        .i_rat_rd_wen_2  (rd_wen[2]),
        .i_rat_rd_wen_3  (rd_wen[3]),
        .i_rat_new_prd_0 (new_prd[0]),
        .i_rat_new_prd_1 (new_prd[1]),
        .i_rat_new_prd_2 (new_prd[2]),
        .i_rat_new_prd_3 (new_prd[3]),
        .i_rat_fl_stall  (fl_stall),
        .i_rat_dsp_stall (dsp_stall),
        .i_rat_flush     (flush),
        .i_rat_cmt_vld_0 (cmt_vld[0]),
        .i_rat_cmt_vld_1 (cmt_vld[1]),
        .i_rat_cmt_vld_2 (cmt_vld[2]),
        .i_rat_cmt_vld_3 (cmt_vld[3]),
        .i_rat_cmt_rd_0  (cmt_rd[0]),
        .i_rat_cmt_rd_1  (cmt_rd[1]),
        .i_rat_cmt_rd_2  (cmt_rd[2]),
        .i_rat_cmt_rd_3  (cmt_rd[3]),
        .i_rat_cmt_prd_0 (cmt_prd[0]),
        .i_rat_cmt_prd_1 (cmt_prd[1]),
        .i_rat_cmt_prd_2 (cmt_prd[2]),
        .i_rat_cmt_prd_3 (cmt_prd[3]),
        .o_rat_vld_0     (o_vld[0]),
        .o_rat_vld_1     (o_vld[1]),
        .o_rat_vld_2     (o_vld[2]),
        .o_rat_vld_3     (o_vld[3]),
        .o_rat_prs1_0    (o_prs1[0]),
        .o_rat_prs1_1    (o_prs1[1]),
        .o_rat_prs1_2    (o_prs1[2]),
        .o_rat_prs1_3    (o_prs1[3]),
        .o_rat_prs2_0    (o_prs2[0]),
        .o_rat_prs2_1    (o_prs2[1]),
        .o_rat_prs2_2    (o_prs2[2]),
        .o_rat_prs2_3    (o_prs2[3]),
        .o_rat_prd_0     (o_prd[0]),
        .o_rat_prd_1     (o_prd[1]),
        .o_rat_prd_2     (o_prd[2]),
        .o_rat_prd_3     (o_prd[3]),
        .o_rat_old_prd_0 (o_old[0]),
        .o_rat_old_prd_1 (o_old[1]),
        .o_rat_old_prd_2 (o_old[2]),
        .o_rat_old_prd_3 (o_old[3]),
        .o_rat_stall     (o_stall)
    );

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    function automatic void check(string name, logic [6:0] act, logic [6:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Reference state: the two tables and the outputs dispatch should currently see.
    logic [6:0] m_srat [32];
    logic [6:0] m_arat [32];
    logic [3:0] e_vld;
    logic [6:0] e_prs1 [4];
    logic [6:0] e_prs2 [4];
    logic [6:0] e_prd  [4];
    logic [6:0] e_old  [4];

    function automatic bit writes(int k);
        return vld[k] && rd_wen[k] && rd[k] != 5'd0;
    endfunction

    // Mapping of arch reg s as seen by slot k: youngest older writer, else sRAT.
    function automatic logic [6:0] lookup(logic [4:0] s, int k);
        logic [6:0] p = m_srat[s];
        for (int j = 0; j < k; j++) if (writes(j) && rd[j] == s) p = new_prd[j];
        return p;
    endfunction

    task automatic model_edge();
        logic [6:0] na [32];
        na = m_arat;
        for (int k = 0; k < 4; k++) if (cmt_vld[k] && cmt_rd[k] != 5'd0) na[cmt_rd[k]] = cmt_prd[k];
        if (flush) begin
            e_vld  = 4'b0;
            m_srat = na;
        end else if (!(fl_stall || dsp_stall)) begin
            e_vld = vld;
            if (vld != 4'b0) begin
                for (int k = 0; k < 4; k++) begin
                    e_prs1[k] = lookup(rs1[k], k);
                    e_prs2[k] = lookup(rs2[k], k);
                    e_prd[k]  = writes(k) ? new_prd[k] : 7'd0;
                    e_old[k]  = writes(k) ? lookup(rd[k], k) : 7'd0;
                end
                for (int k = 0; k < 4; k++) if (writes(k)) m_srat[rd[k]] = new_prd[k];
            end
        end
        m_arat = na;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", {6'd0, o_stall}, {6'd0, fl_stall | dsp_stall});
            for (int k = 0; k < 4; k++) begin
                check($sformatf("vld_%0d", k), {6'd0, o_vld[k]}, {6'd0, e_vld[k]});
                if (e_vld[k]) begin
                    check($sformatf("prs1_%0d", k), o_prs1[k], e_prs1[k]);
                    check($sformatf("prs2_%0d", k), o_prs2[k], e_prs2[k]);
                    check($sformatf("prd_%0d", k), o_prd[k], e_prd[k]);
                    check($sformatf("old_prd_%0d", k), o_old[k], e_old[k]);
                end
            end
        end
    end

    task automatic clear();
        vld = '0; rd_wen = '0; cmt_vld = '0;
        rs1 = '0; rs2 = '0; rd = '0; cmt_rd = '0;
        new_prd = '0; cmt_prd = '0;
        fl_stall = 1'b0; dsp_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic ren(int k, logic [4:0] d, logic [6:0] p);
        vld[k] = 1'b1; rd_wen[k] = 1'b1; rd[k] = d; new_prd[k] = p;
    endtask

    initial begin
        for (int r = 0; r < 32; r++) begin
            m_srat[r] = '0;
            m_arat[r] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            e_prs1[k] = '0; e_prs2[k] = '0; e_prd[k] = '0; e_old[k] = '0;
        end
        e_vld = '0;
        clear();
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            check("rst_vld", {6'd0, o_vld[k]}, 7'd0);
            check("rst_prs1", o_prs1[k], 7'd0);
            check("rst_prs2", o_prs2[k], 7'd0);
            check("rst_prd", o_prd[k], 7'd0);
            check("rst_old", o_old[k], 7'd0);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Fresh table: every source maps to PRF 0.
        clear(); vld[0] = 1'b1; rs1[0] = 5'd5; rs2[0] = 5'd6;
        tick();
        check("t1_vld0", {6'd0, o_vld[0]}, 7'd1);
        check("t1_prs1", o_prs1[0], 7'd0);
        check("t1_prs2", o_prs2[0], 7'd0);

        // Intra-group bypass, youngest writer wins.
        clear(); ren(0, 5'd3, 7'd10);
        ren(1, 5'd3, 7'd11); rs1[1] = 5'd3;
        vld[2] = 1'b1; rs2[2] = 5'd3;
        tick();
        check("t2_prd0", o_prd[0], 7'd10);
        check("t2_old0", o_old[0], 7'd0);
        check("t2_prs1_1", o_prs1[1], 7'd10);
        check("t2_old1", o_old[1], 7'd10);
        check("t2_prs2_2", o_prs2[2], 7'd11);
        check("t2_model_srat3", m_srat[3], 7'd11);

        // x0 destination is not a write.
        clear(); ren(0, 5'd0, 7'd20);
        tick();
        check("t3_prd0", o_prd[0], 7'd0);
        check("t3_old0", o_old[0], 7'd0);
        clear(); vld[0] = 1'b1; rs1[0] = 5'd0; rs2[0] = 5'd3;
        tick();
        check("t3_x0", o_prs1[0], 7'd0);
        check("t3_x3", o_prs2[0], 7'd11);

        // Stall freezes outputs and table; release renames exactly once.
        clear(); ren(0, 5'd4, 7'd30); rs1[0] = 5'd3;
        vld[1] = 1'b1; rs1[1] = 5'd4;
        dsp_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t4_frz_prs2", o_prs2[0], 7'd11);
            check("t4_frz_prd", o_prd[0], 7'd0);
        end
        dsp_stall = 1'b0;
        tick();
        check("t4_prd0", o_prd[0], 7'd30);
        check("t4_prs1_0", o_prs1[0], 7'd11);
        check("t4_prs1_1", o_prs1[1], 7'd30);
        clear();
        tick();
        check("t4_idle_vld", {6'd0, o_vld[0]}, 7'd0);
        clear(); ren(0, 5'd4, 7'd31); rs1[0] = 5'd4;
        tick();
        check("t4_once_old", o_old[0], 7'd30);
        check("t4_once_prs1", o_prs1[0], 7'd30);

        // Flush restores committed mappings only.
        clear(); ren(0, 5'd7, 7'd15); ren(1, 5'd8, 7'd16);
        tick();
        clear(); cmt_vld[0] = 1'b1; cmt_rd[0] = 5'd7; cmt_prd[0] = 7'd15;
        tick();
        clear(); flush = 1'b1; ren(0, 5'd8, 7'd50);
        tick();
        check("t5_flush_vld", {3'd0, o_vld}, 7'd0);
        clear(); vld[0] = 1'b1; rs1[0] = 5'd7; rs2[0] = 5'd8;
        tick();
        check("t5_x7", o_prs1[0], 7'd15);
        check("t5_x8", o_prs2[0], 7'd0);

        // Flush merges a same-cycle commit and discards the rename group.
        clear(); flush = 1'b1; ren(0, 5'd9, 7'd40); rs1[0] = 5'd9;
        cmt_vld[1] = 1'b1; cmt_rd[1] = 5'd9; cmt_prd[1] = 7'd22;
        tick();
        check("t6_flush_vld", {6'd0, o_vld[0]}, 7'd0);
        check("t6_model_arat9", m_arat[9], 7'd22);
        clear(); vld[0] = 1'b1; rs1[0] = 5'd9;
        tick();
        check("t6_srat9", o_prs1[0], 7'd22);
        clear(); ren(0, 5'd9, 7'd41);
        tick();
        clear(); flush = 1'b1;
        tick();
        clear(); vld[0] = 1'b1; rs1[0] = 5'd9;
        tick();
        check("t6_arat9", o_prs1[0], 7'd22);

        // Random traffic over a narrow register range to force collisions.
        for (int c = 0; c < 600; c++) begin
            vld    = 4'($urandom);
            rd_wen = 4'($urandom);
            for (int k = 0; k < 4; k++) begin
                rs1[k]     = 5'($urandom_range(0, 9));
                rs2[k]     = 5'($urandom_range(0, 9));
                rd[k]      = 5'($urandom_range(0, 9));
                new_prd[k] = 7'($urandom_range(1, 127));
                cmt_rd[k]  = 5'($urandom_range(0, 9));
                cmt_prd[k] = 7'($urandom_range(1, 127));
            end
            cmt_vld   = 4'($urandom);
            fl_stall  = ($urandom_range(0, 7) == 0);
            dsp_stall = ($urandom_range(0, 5) == 0);
            flush     = ($urandom_range(0, 11) == 0);
            tick();
        end

        clear();
        tick();
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dec_rat_module.md
Name: dec_rat_module

Overview:
- 4-wide register alias table (RAT) in decode.
- Sits directly downstream of the freelist: consumes its 4 allocated PRF codes and its stall.
- Maps arch sources/dest of up to 4 instructions per cycle to PRF codes; registers results toward dispatch.
- Keeps a speculative RAT (sRAT) and a committed RAT (aRAT); restores sRAT from aRAT on flush.

Parameters:
- ARCH_REGS, 32, number of architectural integer registers; 5-bit index.
- PRF_CODE_WIDTH, 7, PRF code width; matches the shared `PRF_CODE_WIDTH.

Ports:
- clk  in  1  clock; single clock domain.
- rst_n  in  1  asynchronous active-low reset.
- i_rat_vld_0..3  in  1  slot k holds a valid instruction; slots are in program order, 0 is oldest.
- i_rat_rs1_0..3, i_rat_rs2_0..3  in  5  arch source indices.
- i_rat_rd_0..3  in  5  arch destination index.
- i_rat_rd_wen_0..3  in  1  slot writes rd; also drives freelist i_fl_req_k.
- i_rat_new_prd_0..3  in  PRF_CODE_WIDTH  freelist o_fl_prf_code_k.
- i_rat_fl_stall  in  1  freelist o_fl_stall.
- i_rat_dsp_stall  in  1  dispatch backpressure.
- i_rat_flush  in  1  pipeline flush.
- i_rat_cmt_vld_0..3  in  1  commit slot valid.
- i_rat_cmt_rd_0..3  in  5  committed arch rd.
- i_rat_cmt_prd_0..3  in  PRF_CODE_WIDTH  committed PRF code.
- o_rat_vld_0..3  out  1  registered slot valid to dispatch.
- o_rat_prs1_0..3, o_rat_prs2_0..3  out  PRF_CODE_WIDTH  renamed sources.
- o_rat_prd_0..3  out  PRF_CODE_WIDTH  new dest PRF code.
- o_rat_old_prd_0..3  out  PRF_CODE_WIDTH  previous mapping of rd; the ROB frees it at commit.
- o_rat_stall  out  1  combinational = i_rat_fl_stall | i_rat_dsp_stall; upstream holds its group.

Behaviour:
- Reset (async): every sRAT and aRAT entry = 0; all o_rat_* = 0. PRF 0 is the only non-free PRF at freelist reset and backs every arch register.
- x0: rd==0 is treated as rd_wen=0 for all RAT purposes. Sources with index 0 always map to 0.
- Source lookup, slot k, per source s: if some older slot j<k has eff_wen_j and rd_j==s, use i_rat_new_prd_j of the youngest such j; otherwise use sRAT[s].
- o_rat_old_prd_k: same bypass rule applied to rd_k; equals 0 when eff_wen_k=0.
- o_rat_prd_k = i_rat_new_prd_k when eff_wen_k, else 0.
- accept = (|i_rat_vld) & ~o_rat_stall & ~i_rat_flush.
  - On accept, at the next edge: sRAT[rd_k] <= new_prd_k for each eff_wen_k. Same rd in several slots: youngest slot wins.
  - On accept, output regs load the lookup results and o_rat_vld_k <= i_rat_vld_k. Latency is 1 cycle.
- o_rat_stall=1 and no flush: output regs and sRAT hold; upstream inputs are stable.
- No valid input, no stall, no flush: o_rat_vld_* <= 0; the other output fields may hold.
- aRAT update: each edge, aRAT[cmt_rd_k] <= cmt_prd_k for valid commit slots with rd!=0; youngest wins. Commit is never blocked by stall.
- Flush (priority over accept): o_rat_vld_* <= 0; sRAT <= aRAT merged with same-cycle commit writes (aRAT next value).
- Rename inputs in a flush cycle are discarded. The freelist is not charged because flush also gates i_fl_req outside this block.
- Flush and stall in the same cycle: flush wins.
- Invalid slots (vld=0) never update state. eff_wen = vld & rd_wen & (rd!=0).

Decomposition:
- Shared package: ARCH_REG_WIDTH=5, `PRF_CODE_WIDTH, RENAME_WIDTH=4, COMMIT_WIDTH=4.
- One natural sub-module: dec_rat_bypass_module, a purely combinational priority match of one arch index against the older slots' rd/new_prd. Instantiated for rs1, rs2 and rd of slots 1..3.
- Both tables use gnrl_dfflr per entry with INITIAL_VALUE 0.

Test Plan:
- Reset, then slot0 rs1=5 rs2=6 with no prior renames -> next cycle o_rat_prs1_0=0, o_rat_prs2_0=0, o_rat_vld_0=1.
- Group: slot0 rd=3 new=10; slot1 rs1=3 rd=3 new=11; slot2 rs2=3 -> prs1_1=10, old_prd_1=10, prs2_2=11; afterwards sRAT[3]=11.
- rd=0 with wen=1, new=20 -> prd=0, old_prd=0; a later read of x0 returns 0; sRAT unchanged.
- Stall held 3 cycles with the same group -> outputs frozen, sRAT unchanged. Release -> one rename occurs, not repeated.
- Rename x7->15 and x8->16, commit x7->15 only, then flush -> next lookup gives x7=15 and x8=0; o_rat_vld_* = 0 in the cycle after flush.
- Flush in the same cycle as commit x9->22 and a valid rename group -> sRAT[9]=22, no rename outputs, aRAT[9]=22.
